// File: rtl/btn_evt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : btn_evt_pkg
// Purpose  : State encoding shared by the button event decoder.
// Revision : 1.0
// ============================================================================
package btn_evt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRESS = 2'd1,
        ST_HOLD  = 2'd2
    } btn_state_e;

endpackage : btn_evt_pkg
`default_nettype wire

// File: rtl/button_event_decoder.sv
`default_nettype none
// ============================================================================
// Module   : button_event_decoder
// Purpose  : Debounced button level -> press/release/repeat pulses and levels.
// Revision : 1.0
// ============================================================================
module button_event_decoder
    import btn_evt_pkg::*;
#(
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 12_500_000,
    parameter int CNT_W         = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse,
    output logic long_press,
    output logic held
);

    localparam logic [CNT_W-1:0] c_hold_last   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_repeat_last = CNT_W'(REPEAT_CYCLES - 1);

    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             armed_q, armed_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             repeat_q, repeat_d;
    logic             long_q, long_d;
    logic             held_q, held_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        // A button still down from reset must be seen low once before it counts.
        armed_d   = armed_q | ~btn_level;
        press_d   = 1'b0;
        release_d = 1'b0;
        repeat_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (btn_level && armed_q) begin
                    state_d = ST_PRESS;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end
            end
            ST_PRESS: begin
                if (!btn_level) begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else if (cnt_q == c_hold_last) begin
                    state_d  = ST_HOLD;
                    cnt_d    = '0;
                    repeat_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (!btn_level) begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else if (cnt_q == c_repeat_last) begin
                    cnt_d    = '0;
                    repeat_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        held_d = (state_d != ST_IDLE);
        long_d = (state_d == ST_HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            armed_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
            long_q    <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            armed_q   <= armed_d;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
            long_q    <= long_d;
            held_q    <= held_d;
        end
    end

    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign repeat_pulse  = repeat_q;
    assign long_press    = long_q;
    assign held          = held_q;

endmodule : button_event_decoder
`default_nettype wire

// File: tb/tb_button_event_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_event_decoder
// Purpose  : Scoreboard bench with a press-timestamp reference model.
// Revision : 1.0
// ============================================================================
module tb_button_event_decoder;

    localparam int HOLD   = 8;
    localparam int REPEAT = 4;

    logic clk;
    logic rst;
    logic btn_level;
    logic press_pulse, release_pulse, repeat_pulse, long_press, held;

    int tests_run;
    int tests_failed;

    button_event_decoder #(
        .HOLD_CYCLES   (HOLD),
        .REPEAT_CYCLES (REPEAT),
        .CNT_W         (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .repeat_pulse  (repeat_pulse),
        .long_press    (long_press),
        .held          (held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: remembers the edge index at which a press was accepted
    // and derives every output from the elapsed count since then.
    bit   m_armed;
    bit   m_pressed;
    int   m_start;
    int   m_edge;
    logic [4:0] exp_q[$];   // {press, release, repeat, long, held}

    task automatic model_step(input bit r, input bit b, output logic [4:0] e);
        bit pr, rl, rp, lp;
        int d;
        pr = 0; rl = 0; rp = 0;
        if (r) begin
            m_armed   = 0;
            m_pressed = 0;
        end else begin
            if (m_pressed) begin
                if (!b) begin
                    rl        = 1;
                    m_pressed = 0;
                end else begin
                    d = m_edge - m_start;
                    if (d >= HOLD && ((d - HOLD) % REPEAT) == 0) rp = 1;
                end
            end else if (b && m_armed) begin
                m_pressed = 1;
                m_start   = m_edge;
                pr        = 1;
            end
            if (!b) m_armed = 1;
        end
        lp = m_pressed && ((m_edge - m_start) >= HOLD);
        e  = {pr, rl, rp, lp, m_pressed};
        m_edge++;
    endtask

    task automatic drive(input bit r, input bit b, input int n);
        logic [4:0] e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst       = r;
            btn_level = b;
            model_step(r, b, e);
            exp_q.push_back(e);
        end
    endtask

    // Monitor: the DUT presents a full output vector after every edge.
    always @(posedge clk) begin
        logic [4:0] e;
        logic [4:0] a;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {press_pulse, release_pulse, repeat_pulse, long_press, held};
            tests_run++;
            if (a !== e) begin
                tests_failed++;
                $display("FAIL outputs t=%0t got {press,rel,rep,long,held}=%b expected %b",
                         $time, a, e);
            end
        end
    end

    initial begin
        int wait_cnt;
        tests_run    = 0;
        tests_failed = 0;
        m_armed = 0; m_pressed = 0; m_start = 0; m_edge = 0;
        rst       = 1'b1;
        btn_level = 1'b0;

        // 1: short press
        drive(1, 0, 2);
        drive(0, 0, 3);
        drive(0, 1, 3);
        drive(0, 0, 3);
        // 2: long hold with repeats
        drive(0, 1, 20);
        drive(0, 0, 3);
        // 3: held through reset, then a fresh press
        drive(1, 1, 2);
        drive(0, 1, 30);
        drive(0, 0, 2);
        drive(0, 1, 3);
        drive(0, 0, 2);
        // 4: release on the same edge as the hold threshold
        drive(0, 1, 8);
        drive(0, 0, 3);
        // 5: reset during HOLD, button kept down
        drive(0, 1, 12);
        drive(1, 1, 2);
        drive(0, 1, 15);
        drive(0, 0, 3);
        // 6: minimum single-sample press
        drive(0, 1, 1);
        drive(0, 0, 3);

        for (int k = 0; k < 60; k++) begin
            drive(($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
                  $urandom_range(1, 25));
        end
        drive(0, 0, 2);

        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 20) begin
            @(posedge clk);
            wait_cnt++;
        end
        #3;
        if (exp_q.size() > 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL drain got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_button_event_decoder
`default_nettype wire
